// File: rtl/oled_text_refresh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oled_text_refresh_pkg
// Description : Shared geometry, state encodings and address helper for the
//               OLED text refresh sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package oled_text_refresh_pkg;

    localparam int TXT_ROWS  = 4;
    localparam int TXT_COLS  = 16;
    localparam int CELL_W    = 6;
    localparam int NUM_CELLS = TXT_ROWS * TXT_COLS;

    localparam logic [CELL_W-1:0] LAST_CELL = 6'd63;

    // 8-bit encodings, matching the controller's state style
    typedef enum logic [7:0] {
        ST_IDLE      = 8'h00,
        ST_SCAN      = 8'h01,
        ST_FETCH     = 8'h02,
        ST_WR_RDY    = 8'h03,
        ST_WR_ISSUE  = 8'h04,
        ST_WR_LO     = 8'h05,
        ST_WR_HI     = 8'h06,
        ST_UPD_RDY   = 8'h07,
        ST_UPD_ISSUE = 8'h08,
        ST_UPD_LO    = 8'h09,
        ST_UPD_HI    = 8'h0A,
        ST_DONE      = 8'h0B
    } state_t;

    // {row, col, 3'b000}: each character cell is 8 pixel columns wide
    function automatic logic [8:0] cell_base_addr(input logic [CELL_W-1:0] idx);
        return {idx[5:4], idx[3:0], 3'b000};
    endfunction

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WR_RDY)  || (s == ST_WR_LO)  || (s == ST_WR_HI) ||
               (s == ST_UPD_RDY) || (s == ST_UPD_LO) || (s == ST_UPD_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oled_text_refresh_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : oled_text_refresh_text_buffer
// Description : 64x8 simple dual-port text RAM; port A host write, port B
//               registered read. Contents preset to BLANK_CHAR at load time.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_text_refresh_text_buffer
    import oled_text_refresh_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [CELL_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [CELL_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_q [NUM_CELLS] = '{default: BLANK_CHAR};
    logic [7:0] rd_data_q;

    // No reset: the image survives a sequencer reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/oled_text_refresh.sv
`default_nettype none
// ============================================================================
// Module      : oled_text_refresh
// Description : Holds a 4x16 text image with per-cell dirty bits and streams
//               changed cells to the OLED controller, then requests an update.
// Revision    : 1.0 - initial release
// ============================================================================
module oled_text_refresh
    import oled_text_refresh_pkg::*;
#(
    parameter logic [7:0]  BLANK_CHAR  = 8'h20,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txt_we,
    input  logic [5:0]  txt_addr,
    input  logic [7:0]  txt_data,
    input  logic        refresh_start,
    input  logic        refresh_full,
    output logic        refresh_busy,
    output logic        refresh_done,
    output logic        refresh_err,
    output logic        write_start,
    output logic [7:0]  write_ascii_data,
    output logic [8:0]  write_base_addr,
    input  logic        write_ready,
    output logic        update_start,
    output logic        update_clear,
    input  logic        update_ready
);

    state_t                state_q, state_d;
    logic [CELL_W-1:0]     idx_q, idx_d;
    logic                  full_q, full_d;
    logic                  sent_q, sent_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [7:0]            ascii_q, ascii_d;
    logic [NUM_CELLS-1:0]  dirty_q, dirty_d;
    logic [31:0]           tmo_q, tmo_d;
    logic                  tmo_hit;
    logic [7:0]            rd_data;

    oled_text_refresh_text_buffer #(
        .BLANK_CHAR (BLANK_CHAR)
    ) u_text_buffer (
        .clk     (clk),
        .wr_en   (txt_we),
        .wr_addr (txt_addr),
        .wr_data (txt_data),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == (TIMEOUT_CYC - 32'd1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        full_d       = full_q;
        sent_d       = sent_q;
        err_d        = err_q;
        busy_d       = busy_q;
        ascii_d      = ascii_q;
        dirty_d      = dirty_q;
        tmo_d        = '0;
        write_start  = 1'b0;
        update_start = 1'b0;
        refresh_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (refresh_start) begin
                    full_d  = refresh_full;
                    idx_d   = '0;
                    sent_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (dirty_q[idx_q] || full_q) begin
                    state_d = ST_FETCH;
                end else if (idx_q == LAST_CELL) begin
                    state_d = ST_UPD_RDY;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_FETCH: begin
                ascii_d = rd_data;
                state_d = ST_WR_RDY;
            end
            ST_WR_RDY: begin
                if (write_ready) begin
                    state_d = ST_WR_ISSUE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR_ISSUE: begin
                write_start     = 1'b1;
                dirty_d[idx_q]  = 1'b0;
                sent_d          = 1'b1;
                state_d         = ST_WR_LO;
            end
            ST_WR_LO: begin
                if (!write_ready) begin
                    state_d = ST_WR_HI;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR_HI: begin
                if (write_ready) begin
                    if (idx_q == LAST_CELL) begin
                        state_d = ST_UPD_RDY;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = ST_SCAN;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_UPD_RDY: begin
                if (!sent_q && !full_q) begin
                    state_d = ST_DONE;
                end else if (update_ready) begin
                    state_d = ST_UPD_ISSUE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_UPD_ISSUE: begin
                update_start = 1'b1;
                state_d      = ST_UPD_LO;
            end
            ST_UPD_LO: begin
                if (!update_ready) begin
                    state_d = ST_UPD_HI;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_UPD_HI: begin
                if (update_ready) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                refresh_done = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Host write lands after the issue-clear so a same-cycle write keeps the cell dirty
        if (txt_we) begin
            dirty_d[txt_addr] = 1'b1;
        end

        if ((state_d == state_q) && is_wait_state(state_q)) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            full_q  <= 1'b0;
            sent_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ascii_q <= '0;
            dirty_q <= '1;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ascii_q <= ascii_d;
            dirty_q <= dirty_d;
            tmo_q   <= tmo_d;
        end
    end

    assign refresh_busy     = busy_q;
    assign refresh_err      = err_q;
    assign write_ascii_data = ascii_q;
    assign write_base_addr  = cell_base_addr(idx_q);
    assign update_clear     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_oled_text_refresh.sv
`default_nettype none
// ============================================================================
// Module      : tb_oled_text_refresh
// Description : Directed bench for oled_text_refresh with a small OLED
//               controller handshake model and write/update monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_oled_text_refresh;

    logic       clk = 1'b0;
    logic       rst;
    logic       txt_we;
    logic [5:0] txt_addr;
    logic [7:0] txt_data;
    logic       refresh_start;
    logic       refresh_full;
    logic       refresh_busy;
    logic       refresh_done;
    logic       refresh_err;
    logic       write_start;
    logic [7:0] write_ascii_data;
    logic [8:0] write_base_addr;
    logic       write_ready;
    logic       update_start;
    logic       update_clear;
    logic       update_ready;

    int n_chk = 0;
    int n_bad = 0;

    logic [8:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         upd_n;
    int         done_n;

    bit ctrl_alive;
    int wr_cnt;
    int up_cnt;

    always #5 clk = ~clk;

    oled_text_refresh #(
        .BLANK_CHAR  (8'h20),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .txt_we           (txt_we),
        .txt_addr         (txt_addr),
        .txt_data         (txt_data),
        .refresh_start    (refresh_start),
        .refresh_full     (refresh_full),
        .refresh_busy     (refresh_busy),
        .refresh_done     (refresh_done),
        .refresh_err      (refresh_err),
        .write_start      (write_start),
        .write_ascii_data (write_ascii_data),
        .write_base_addr  (write_base_addr),
        .write_ready      (write_ready),
        .update_start     (update_start),
        .update_clear     (update_clear),
        .update_ready     (update_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Controller model: ready drops for 3 cycles after each request
    initial begin
        write_ready = 1'b0;
        update_ready = 1'b0;
        wr_cnt = 0;
        up_cnt = 0;
        forever begin
            @(negedge clk);
            if (!ctrl_alive) begin
                write_ready  = 1'b0;
                update_ready = 1'b0;
                wr_cnt = 0;
                up_cnt = 0;
            end else begin
                if (write_start) wr_cnt = 3;
                if (wr_cnt > 0) begin
                    wr_cnt--;
                    write_ready = 1'b0;
                end else begin
                    write_ready = 1'b1;
                end
                if (update_start) up_cnt = 3;
                if (up_cnt > 0) begin
                    up_cnt--;
                    update_ready = 1'b0;
                end else begin
                    update_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (write_start) begin
                wa_q.push_back(write_base_addr);
                wd_q.push_back(write_ascii_data);
            end
            if (update_start) upd_n++;
            if (refresh_done) done_n++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        upd_n  = 0;
        done_n = 0;
    endtask

    task automatic host_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        txt_we = 1'b1; txt_addr = a; txt_data = d;
        @(negedge clk);
        txt_we = 1'b0;
    endtask

    // Cycles counted from the edge that accepts refresh_start to the done pulse
    task automatic do_refresh(input logic full, output int cycles);
        bit found;
        clear_mon();
        @(negedge clk);
        refresh_start = 1'b1; refresh_full = full;
        @(negedge clk);
        refresh_start = 1'b0; refresh_full = 1'b0;
        cycles = 1;
        found  = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (refresh_done) found = 1'b1;
        end
        chk("done_seen", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  cyc;
        bit  found;
        rst = 1'b1;
        txt_we = 1'b0; txt_addr = '0; txt_data = '0;
        refresh_start = 1'b0; refresh_full = 1'b0;
        ctrl_alive = 1'b1;
        upd_n = 0; done_n = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_outs", 32'({write_start, update_start, refresh_busy, refresh_done,
                             refresh_err, write_ascii_data, write_base_addr, update_clear}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // T1: power-up image is entirely dirty and blank
        do_refresh(1'b0, cyc);
        chk("t1_nwr", 32'(wa_q.size()), 32'd64);
        if (wa_q.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("t1_addr", 32'(wa_q[i]), 32'(i * 8));
                chk("t1_data", 32'(wd_q[i]), 32'h20);
            end
        end
        chk("t1_upd", 32'(upd_n), 32'd1);
        chk("t1_done", 32'(done_n), 32'd1);
        chk("t1_err", 32'(refresh_err), 32'd0);
        chk("t1_busy", 32'(refresh_busy), 32'd0);

        // T2: two host writes, sent in cell order
        host_write(6'h05, 8'h41);
        host_write(6'h3F, 8'h5A);
        do_refresh(1'b0, cyc);
        chk("t2_nwr", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("t2_a0", 32'(wa_q[0]), 32'h028);
            chk("t2_d0", 32'(wd_q[0]), 32'h41);
            chk("t2_a1", 32'(wa_q[1]), 32'h1F8);
            chk("t2_d1", 32'(wd_q[1]), 32'h5A);
        end
        chk("t2_upd", 32'(upd_n), 32'd1);

        // T3: nothing dirty
        do_refresh(1'b0, cyc);
        chk("t3_nwr", 32'(wa_q.size()), 32'd0);
        chk("t3_upd", 32'(upd_n), 32'd0);
        chk("t3_lat", 32'(cyc <= 66), 32'd1);
        chk("t3_done", 32'(done_n), 32'd1);

        // T4: dead controller forces the timeout path
        ctrl_alive = 1'b0;
        repeat (2) @(negedge clk);
        do_refresh(1'b1, cyc);
        chk("t4_err", 32'(refresh_err), 32'd1);
        chk("t4_nwr", 32'(wa_q.size()), 32'd0);
        chk("t4_upd", 32'(upd_n), 32'd0);
        chk("t4_lat", 32'((cyc >= 100) && (cyc <= 106)), 32'd1);
        ctrl_alive = 1'b1;
        repeat (2) @(negedge clk);
        do_refresh(1'b1, cyc);
        chk("t4_err_clr", 32'(refresh_err), 32'd0);
        chk("t4_full_nwr", 32'(wa_q.size()), 32'd64);
        chk("t4_full_upd", 32'(upd_n), 32'd1);

        // T5: host write to cell 3 during its WR_ISSUE cycle
        host_write(6'h03, 8'h42);
        fork
            do_refresh(1'b0, cyc);
            begin
                bit hit;
                hit = 1'b0;
                for (int c = 0; c < 300 && !hit; c++) begin
                    @(negedge clk);
                    if (write_start) begin
                        hit = 1'b1;
                        txt_we = 1'b1; txt_addr = 6'h03; txt_data = 8'h43;
                        @(negedge clk);
                        txt_we = 1'b0;
                    end
                end
            end
        join
        chk("t5_nwr", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("t5_a", 32'(wa_q[0]), 32'h018);
            chk("t5_d_old", 32'(wd_q[0]), 32'h42);
        end
        do_refresh(1'b0, cyc);
        chk("t5_again_nwr", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("t5_a2", 32'(wa_q[0]), 32'h018);
            chk("t5_d_new", 32'(wd_q[0]), 32'h43);
        end

        // T6: reset while waiting in WR_LO
        clear_mon();
        @(negedge clk);
        refresh_start = 1'b1; refresh_full = 1'b1;
        @(negedge clk);
        refresh_start = 1'b0; refresh_full = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (write_start) found = 1'b1;
        end
        chk("t6_wr_seen", 32'(found), 32'd1);
        @(negedge clk);
        chk("t6_busy", 32'(refresh_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", 32'({write_start, update_start, refresh_busy, refresh_done,
                                refresh_err, write_ascii_data, write_base_addr, update_clear}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        do_refresh(1'b0, cyc);
        chk("t6_nwr", 32'(wa_q.size()), 32'd64);
        chk("t6_upd", 32'(upd_n), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
